// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master: START / one data byte + ACK / STOP sequencer with quarter-period prescaler.
// Optional macro I2C_CLK_STRETCH_EN freezes the prescaler while a slave holds SCL low.
module i2c_master_byte_ctrl #(
  parameter int PRESCALE_W = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [PRESCALE_W-1:0] clk_cnt,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  read,
  input  logic                  write,
  input  logic                  ack_in,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  cmd_ack,
  output logic                  ack_out,
  output logic                  busy,
  input  logic                  scl_i,
  output logic                  scl_o,
  output logic                  scl_oen,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  sda_oen
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state;
  logic [1:0]            phase;
  logic [2:0]            bit_cnt;
  logic [PRESCALE_W-1:0] cnt;
  logic [DATA_WIDTH-1:0] sr;
  logic                  c_rw, c_write, c_stop, ack_bit;
  logic                  scl_q, sda_q;
  logic                  drv_scl, drv_sda;
  logic                  active, stretch, tick;

  assign scl_o   = 1'b0;
  assign sda_o   = 1'b0;
  assign scl_oen = drv_scl;
  assign sda_oen = drv_sda;

  assign active = (state == S_START) || (state == S_DATA) ||
                  (state == S_ACK)   || (state == S_STOP);

  // Outside a transfer the lines keep their last driven level so the bus stays owned between commands.
  always_comb begin
    drv_scl = scl_q;
    drv_sda = sda_q;
    case (state)
      S_START: begin
        drv_scl = (phase != 2'd3);
        drv_sda = (phase < 2'd2);
      end
      S_STOP: begin
        drv_scl = (phase != 2'd0);
        drv_sda = (phase == 2'd3);
      end
      S_DATA: begin
        drv_scl = (phase == 2'd1) || (phase == 2'd2);
        drv_sda = c_write ? sr[DATA_WIDTH-1] : 1'b1;
      end
      S_ACK: begin
        drv_scl = (phase == 2'd1) || (phase == 2'd2);
        drv_sda = c_write ? 1'b1 : ack_bit;
      end
      default: ;
    endcase
  end

`ifdef I2C_CLK_STRETCH_EN
  assign stretch = active && ((phase == 2'd1) || (phase == 2'd2)) && drv_scl && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stretch      = 1'b0;
`endif

  assign tick = active && ena && !stretch && (cnt == clk_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      sr      <= '0;
      c_rw    <= 1'b0;
      c_write <= 1'b0;
      c_stop  <= 1'b0;
      ack_bit <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      dout    <= '0;
      ack_out <= 1'b0;
      busy    <= 1'b0;
      cmd_ack <= 1'b0;
    end else begin
      scl_q   <= drv_scl;
      sda_q   <= drv_sda;
      cmd_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ena && (start || stop || read || write)) begin
            c_rw    <= read || write;
            c_write <= write;
            c_stop  <= stop;
            ack_bit <= ack_in;
            sr      <= din;
            cnt     <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            state   <= start ? S_START : ((read || write) ? S_DATA : S_STOP);
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          if (ena && !stretch)
            cnt <= (cnt == clk_cnt) ? '0 : cnt + 1'b1;
          if (tick) begin
            phase <= phase + 2'd1;
            if (phase == 2'd1) begin
              if (state == S_START)
                busy <= 1'b1;
              if (state == S_DATA && !c_write)
                sr <= {sr[DATA_WIDTH-2:0], sda_i};
              if (state == S_ACK && c_write)
                ack_out <= sda_i;
            end
            if (phase == 2'd3) begin
              case (state)
                S_START: begin
                  if (c_rw)
                    state <= S_DATA;
                  else if (c_stop)
                    state <= S_STOP;
                  else begin
                    state   <= S_DONE;
                    cmd_ack <= 1'b1;
                  end
                end
                S_DATA: begin
                  if (c_write)
                    sr <= {sr[DATA_WIDTH-2:0], 1'b0};
                  if (bit_cnt == 3'd7)
                    state <= S_ACK;
                  else
                    bit_cnt <= bit_cnt + 3'd1;
                end
                S_ACK: begin
                  if (!c_write)
                    dout <= sr;
                  if (c_stop)
                    state <= S_STOP;
                  else begin
                    state   <= S_DONE;
                    cmd_ack <= 1'b1;
                  end
                end
                default: begin
                  busy    <= 1'b0;
                  state   <= S_DONE;
                  cmd_ack <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: quarter-period line model, slave emulation and literal latency pins.
module tb_i2c_master_byte_ctrl;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic [15:0] clk_cnt;
  logic        start, stop, read, write, ack_in;
  logic [7:0]  din, dout;
  logic        cmd_ack, ack_out, busy;
  logic        scl_i, scl_o, scl_oen, sda_i, sda_o, sda_oen;

  logic slave_v = 1'b1;
  logic stretch_low = 1'b0;

  assign sda_i = sda_oen & slave_v;
  assign scl_i = scl_oen & ~stretch_low;

  always #5 clk = ~clk;

  i2c_master_byte_ctrl #(.PRESCALE_W(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .clk_cnt(clk_cnt),
    .start(start), .stop(stop), .read(read), .write(write),
    .ack_in(ack_in), .din(din), .dout(dout), .cmd_ack(cmd_ack),
    .ack_out(ack_out), .busy(busy),
    .scl_i(scl_i), .scl_o(scl_o), .scl_oen(scl_oen),
    .sda_i(sda_i), .sda_o(sda_o), .sda_oen(sda_oen)
  );

`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_EXTRA = 50;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: expected line levels per quarter, plus persistent result registers.
  bit   exp_scl[$], exp_sda[$], exp_busy[$], slv_q[$];
  bit   m_busy = 0;
  logic [7:0] m_dout = 8'h00;
  bit   m_ack = 0;
  int   cc = 4;

  task automatic add_q(input bit s, input bit d, input bit b, input bit v);
    exp_scl.push_back(s); exp_sda.push_back(d); exp_busy.push_back(b); slv_q.push_back(v);
  endtask

  task automatic wbit(input bit v);
    add_q(0, v, m_busy, 1); add_q(1, v, m_busy, 1); add_q(1, v, m_busy, 1); add_q(0, v, m_busy, 1);
  endtask

  task automatic rbit(input bit v);
    add_q(0, 1, m_busy, v); add_q(1, 1, m_busy, v); add_q(1, 1, m_busy, v); add_q(0, 1, m_busy, v);
  endtask

  task automatic build(input bit st, input bit rd, input bit wr, input bit sp,
                       input logic [7:0] d, input bit ai, input logic [7:0] sbyte, input bit sack);
    exp_scl.delete(); exp_sda.delete(); exp_busy.delete(); slv_q.delete();
    if (st) begin
      add_q(1, 1, m_busy, 1); add_q(1, 1, m_busy, 1);
      m_busy = 1;
      add_q(1, 0, 1, 1); add_q(0, 0, 1, 1);
    end
    if (wr) begin
      for (int i = 7; i >= 0; i--) wbit(d[i]);
      rbit(sack);
      m_ack = sack;
    end else if (rd) begin
      for (int i = 7; i >= 0; i--) rbit(sbyte[i]);
      wbit(ai);
      m_dout = sbyte;
    end
    if (sp) begin
      add_q(0, 0, m_busy, 1); add_q(1, 0, m_busy, 1); add_q(1, 0, m_busy, 1); add_q(1, 1, m_busy, 1);
      m_busy = 0;
    end
  endtask

  // Per-cycle compare against the quarter model while a transaction is in flight.
  bit active = 0, done = 0;
  int kc = -1;

  always @(posedge clk) begin
    int qq, nq;
    #1;
    if (active) begin
      kc++;
      nq = exp_scl.size();
      qq = kc / (cc + 1);
      if (qq < nq) begin
        slave_v = slv_q[qq];
        chk("scl_oen", scl_oen, exp_scl[qq]);
        chk("sda_oen", sda_oen, exp_sda[qq]);
        chk("busy", busy, exp_busy[qq]);
        chk("cmd_ack_idle", cmd_ack, 0);
      end else begin
        slave_v = 1'b1;
        if (kc == nq * (cc + 1)) begin
          chk("cmd_ack_pulse", cmd_ack, 1);
          chk("busy_end", busy, m_busy);
          chk("dout", dout, m_dout);
          chk("ack_out", ack_out, m_ack);
          chk("scl_hold", scl_oen, exp_scl[nq-1]);
          chk("sda_hold", sda_oen, exp_sda[nq-1]);
        end else begin
          chk("cmd_ack_after", cmd_ack, 0);
          active = 0;
          done   = 1;
        end
      end
    end
  end

  task automatic run_txn(input bit st, input bit rd, input bit wr, input bit sp,
                         input logic [7:0] d, input bit ai, input logic [7:0] sbyte,
                         input bit sack, output int lat);
    int limit;
    build(st, rd, wr, sp, d, ai, sbyte, sack);
    limit = exp_scl.size() * (cc + 1) + 20;
    @(negedge clk);
    clk_cnt = cc[15:0];
    start = st; read = rd; write = wr; stop = sp; din = d; ack_in = ai;
    kc = -1; done = 0; active = 1;
    lat = -1;
    for (int j = 0; j < limit && !done; j++) begin
      @(posedge clk); #3;
      if (j == 0) begin start = 0; read = 0; write = 0; stop = 0; end
      if (cmd_ack && lat < 0) lat = j;
    end
    if (!done) begin
      active = 0;
      chk("txn_timeout", 0, 1);
    end
  endtask

  int lat;
  bit seen_ack;

  initial begin
    rst = 1; ena = 1; clk_cnt = 16'd4;
    start = 0; stop = 0; read = 0; write = 0; ack_in = 0; din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl_oen", scl_oen, 1);
    chk("rst_sda_oen", sda_oen, 1);
    chk("rst_cmd_ack", cmd_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_ack_out", ack_out, 0);
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);

    // start + write 0xA5, slave ACKs
    cc = 4;
    run_txn(1, 0, 1, 0, 8'hA5, 0, 8'h00, 0, lat);
    chk("lat_start_write", lat, 200);
    chk("ack_out_a5", ack_out, 0);
    chk("busy_after_start", busy, 1);

    // start + read + stop with NACK, slave sends 0x3C
    run_txn(1, 1, 0, 1, 8'h00, 1, 8'h3C, 0, lat);
    chk("lat_read_stop", lat, 220);
    chk("dout_3c", dout, 8'h3C);
    chk("busy_after_stop", busy, 0);

    // slave leaves SDA high on the ack bit
    run_txn(1, 0, 1, 1, 8'h5A, 0, 8'h00, 1, lat);
    chk("lat_write_nack", lat, 220);
    chk("ack_out_nack", ack_out, 1);

    // start-only then stop-only
    cc = 1;
    run_txn(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, lat);
    chk("lat_start_only", lat, 8);
    chk("busy_start_only", busy, 1);
    run_txn(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, lat);
    chk("lat_stop_only", lat, 8);
    chk("busy_stop_only", busy, 0);

    // read and write together: the write is performed
    cc = 2;
    run_txn(1, 1, 1, 1, 8'hC3, 0, 8'hFF, 0, lat);
    chk("lat_rw", lat, 132);
    chk("dout_kept", dout, 8'h3C);
    chk("ack_out_rw", ack_out, 0);

    // minimum quarter length
    cc = 0;
    run_txn(1, 0, 1, 1, 8'h81, 0, 8'h00, 0, lat);
    chk("lat_cc0", lat, 44);

    // reset in the middle of a byte
    cc = 4;
    @(negedge clk);
    clk_cnt = 16'd4; start = 1; write = 1; din = 8'hF0;
    @(negedge clk);
    start = 0; write = 0;
    repeat (60) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("abort_scl_oen", scl_oen, 1);
    chk("abort_sda_oen", sda_oen, 1);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_ack", cmd_ack, 0);
    chk("abort_dout", dout, 8'h00);
    @(negedge clk); rst = 0;
    m_busy = 0; m_dout = 8'h00; m_ack = 0;
    seen_ack = 0;
    repeat (250) begin
      @(negedge clk);
      if (cmd_ack) seen_ack = 1;
    end
    chk("abort_no_cmd_ack", seen_ack, 0);
    chk("abort_idle_scl", scl_oen, 1);

    // slave stretches SCL for 50 cycles during P2 of the first data bit
    @(negedge clk);
    clk_cnt = 16'd4; start = 1; write = 1; stop = 1; din = 8'h00;
    lat = -1;
    for (int j = 0; j < 400 && lat < 0; j++) begin
      @(posedge clk); #1;
      if (j == 0) begin start = 0; write = 0; stop = 0; end
      stretch_low = (j >= 25 && j < 75);
      if (cmd_ack) lat = j;
    end
    stretch_low = 0;
    chk("lat_stretch", lat, 220 + STRETCH_EXTRA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
